// File: rtl/tb_clk_div.sv
// Programmable integer clock divider: 50 % duty clk_o with period 2*D base cycles,
// glitch-free runtime divisor changes via a one-entry pending register and valid/ack.
module tb_clk_div #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ack_o,
  output logic                 clk_o,
  output logic                 tick_o,
  output logic                 busy_o,
  output logic [DIV_WIDTH-1:0] div_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0] div_nxt;
  logic [DIV_WIDTH-1:0] pend_div;
  logic                 pend_vld, pend_vld_nxt;
  logic                 start, consume, accept, last;

  // Terminal half-period count; a stored divisor of 0 behaves as 1.
  function automatic logic [DIV_WIDTH-1:0] last_cnt(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DIV_WIDTH'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + DIV_WIDTH'(1);
    start     = 1'b0;
    last      = (cnt == last_cnt(div_o));
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en_i) begin
          state_nxt = HIGH;
          start     = 1'b1;
        end
      end
      HIGH: begin
        if (last) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        if (last) begin
          cnt_nxt = '0;
          if (en_i) begin
            state_nxt = HIGH;
            start     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A consuming edge still sees pend_vld=1, so a waiting request is taken one edge later.
  always_comb begin
    consume      = start && pend_vld;
    accept       = div_valid_i && !pend_vld && !div_ack_o;
    div_nxt      = consume ? pend_div : div_o;
    pend_vld_nxt = pend_vld;
    if (consume)     pend_vld_nxt = 1'b0;
    else if (accept) pend_vld_nxt = 1'b1;
  end

  // Registered state and outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      clk_o     <= 1'b0;
      tick_o    <= 1'b0;
      busy_o    <= 1'b0;
      div_o     <= DIV_WIDTH'(DEFAULT_DIV);
      pend_vld  <= 1'b0;
      div_ack_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      clk_o     <= (state_nxt == HIGH);
      tick_o    <= start;
      busy_o    <= (state_nxt != IDLE);
      div_o     <= div_nxt;
      pend_vld  <= pend_vld_nxt;
      div_ack_o <= accept;
    end
  end

  // Pending divisor payload; validity is tracked by pend_vld alone
  always_ff @(posedge clk_i) begin
    if (accept) pend_div <= div_i;
  end

endmodule

// File: tb/tb_tb_clk_div.sv
// Directed bench for tb_clk_div: per-cycle vector table plus hand-written
// sequences for divisor chaining, divisor 0 and asynchronous reset.
module tb_tb_clk_div;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic [DW-1:0] div_i;
  logic          div_valid_i;
  logic          div_ack_o, clk_o, tick_o, busy_o;
  logic [DW-1:0] div_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk_i = ~clk_i;

  tb_clk_div #(.DIV_WIDTH(DW), .DEFAULT_DIV(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ack_o   (div_ack_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .busy_o      (busy_o),
    .div_o       (div_o)
  );

  typedef struct {
    logic          en;
    logic          dv;
    logic [DW-1:0] d;
    logic          clk;
    logic          tick;
    logic          busy;
    logic          ack;
    logic [DW-1:0] divo;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic add(input logic en, input logic dv, input logic [DW-1:0] d,
                     input logic c, input logic t, input logic b, input logic a,
                     input logic [DW-1:0] dq);
    vec_t v;
    v.en = en; v.dv = dv; v.d = d; v.clk = c; v.tick = t; v.busy = b; v.ack = a; v.divo = dq;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; en_i = 1'b0; div_valid_i = 1'b0; div_i = '0;
    step();
    step();
    check("rst_clk", clk_o, 0);
    check("rst_tick", tick_o, 0);
    check("rst_ack", div_ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_div", div_o, 4);
    rst_ni = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick_o !== 1'b1 && n < limit);
    check("tick_seen", tick_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int n;
    logic exp_ack, exp_tick;
    logic [DW-1:0] exp_div;

    // en, dv, d | clk, tick, busy, ack, div_o  (inputs in cycle r, outputs in cycle r+1)
    add(1,0,0, 1,1,1,0,4);  // c1 start
    add(1,0,0, 1,0,1,0,4);  // c2
    add(1,1,2, 1,0,1,1,4);  // c3 request 2 made in cycle 2, ack now
    add(1,0,0, 1,0,1,0,4);  // c4
    add(1,0,0, 0,0,1,0,4);  // c5
    add(1,0,0, 0,0,1,0,4);
    add(1,0,0, 0,0,1,0,4);
    add(1,0,0, 0,0,1,0,4);  // c8
    add(1,0,0, 1,1,1,0,2);  // c9 period start, new divisor
    add(1,0,0, 1,0,1,0,2);
    add(1,0,0, 0,0,1,0,2);
    add(1,0,0, 0,0,1,0,2);  // c12
    add(1,0,0, 1,1,1,0,2);  // c13
    add(1,0,0, 1,0,1,0,2);
    add(1,0,0, 0,0,1,0,2);
    add(1,0,0, 0,0,1,0,2);  // c16
    add(1,0,0, 1,1,1,0,2);  // c17
    add(0,0,0, 1,0,1,0,2);  // c18 en dropped while HIGH
    add(0,0,0, 0,0,1,0,2);
    add(0,0,0, 0,0,1,0,2);  // c20 low phase completes
    add(0,0,0, 0,0,0,0,2);  // c21 IDLE
    add(0,0,0, 0,0,0,0,2);
    add(0,0,0, 0,0,0,0,2);

    do_reset();
    foreach (tbl[i]) begin
      en_i = tbl[i].en; div_valid_i = tbl[i].dv; div_i = tbl[i].d;
      step();
      check("tbl_clk", clk_o, tbl[i].clk);
      check("tbl_tick", tick_o, tbl[i].tick);
      check("tbl_busy", busy_o, tbl[i].busy);
      check("tbl_ack", div_ack_o, tbl[i].ack);
      check("tbl_div", div_o, tbl[i].divo);
    end

    // Divisor 1 written while stopped, then run
    do_reset();
    div_valid_i = 1'b1; div_i = 8'd1;
    step();
    check("d1_ack", div_ack_o, 1);
    check("d1_busy_idle", busy_o, 0);
    div_valid_i = 1'b0; en_i = 1'b1;
    step();
    check("d1_div", div_o, 1);
    for (int j = 0; j < 8; j++) begin
      check("d1_clk", clk_o, (j % 2 == 0) ? 1 : 0);
      check("d1_tick", tick_o, (j % 2 == 0) ? 1 : 0);
      step();
    end

    // Chained requests 6 then 3: second waits for the period start
    do_reset();
    en_i = 1'b1;
    step();
    check("ch_tick1", tick_o, 1);
    div_valid_i = 1'b1; div_i = 8'd6;
    step();
    check("ch_ack6", div_ack_o, 1);
    div_valid_i = 1'b0;
    step();
    div_valid_i = 1'b1; div_i = 8'd3;
    while (cyc < 30) begin
      step();
      exp_ack  = (cyc == 10);
      exp_tick = (cyc == 9) || (cyc == 21) || (cyc == 27);
      exp_div  = (cyc < 9) ? 8'd4 : (cyc < 21) ? 8'd6 : 8'd3;
      check("ch_ack", div_ack_o, exp_ack);
      check("ch_tick", tick_o, exp_tick);
      check("ch_div", div_o, exp_div);
      if (div_ack_o === 1'b1) div_valid_i = 1'b0;
    end

    // Divisor 0 stored as 0, runs as 1
    div_valid_i = 1'b1; div_i = 8'd0;
    step();
    check("d0_ack", div_ack_o, 1);
    div_valid_i = 1'b0;
    wait_tick(20, n);
    check("d0_div", div_o, 0);
    check("d0_clk_hi", clk_o, 1);
    wait_tick(20, p);
    check("d0_period", p, 2);
    wait_tick(20, p);
    check("d0_period2", p, 2);

    // Reset mid-HIGH drops the pending divisor
    do_reset();
    en_i = 1'b1;
    step();
    step();
    div_valid_i = 1'b1; div_i = 8'd5;
    step();
    check("rh_ack5", div_ack_o, 1);
    check("rh_clk_hi", clk_o, 1);
    div_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("rh_clk", clk_o, 0);
    check("rh_busy", busy_o, 0);
    check("rh_tick", tick_o, 0);
    check("rh_ack", div_ack_o, 0);
    check("rh_div", div_o, 4);
    #1 rst_ni = 1'b1;
    wait_tick(20, n);
    check("rh_div_run", div_o, 4);
    wait_tick(40, p);
    check("rh_period", p, 8);
    check("rh_div_after", div_o, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
